morse_char_decode_fifo: RTL and testbench
=========================================

// Module: morse_char_decode_fifo
// PURPOSE
//   Downstream stage of MORSE_CAPTURE_CHAR. On each capture strobe it decodes the
//   captured element pattern into an 8-bit ASCII code and pushes it into an output FIFO.
//   On a word end it also pushes a space character.
//   The FIFO drains over a valid/ready interface to the text/UART sink.
// PARAMETERS
//   LEN_W       `MORSE_LEN_W     width of len input
//   MAX_LEN     `MAX_MORSE_LEN   width of dits_dahs input (must be >= 6)
//   FIFO_DEPTH  8                entries, power of 2, >= 2
//   CNT_W       4                width of level output = log2(FIFO_DEPTH)+1
// PORTS
//   clk        in   1        system clock
//   rst        in   1        reset, asynchronous, active-high
//   ce         in   1        clock enable; when 0 all state is frozen
//   clear      in   1        synchronous flush of FIFO, pending space and overflow (needs ce)
//   cap_ceo    in   1        capture strobe (MORSE_CAPTURE_CHAR ceo), 1 cycle wide
//   cap_len    in   LEN_W    number of elements in the captured char
//   cap_dd     in   MAX_LEN  elements; bit len-1 = first sent; 1 = dah, 0 = dit
//   cap_error  in   1        capture reported a timing error
//   cap_word   in   1        capture ended on a word gap
//   char_data  out  8        ASCII at FIFO head (show-ahead)
//   char_valid out  1        FIFO not empty
//   char_ready in   1        sink accepts char_data this cycle
//   level      out  CNT_W    current FIFO occupancy, 0..FIFO_DEPTH
//   overflow   out  1        sticky: a push was dropped
// BEHAVIOUR
//   Reset: FIFO empty, char_valid=0, char_data=0, level=0, overflow=0, FSM=IDLE.
//   Every action below requires ce=1. clear has priority over all other actions.
//   Decode (combinational, from the cap_* inputs):
//   - cap_error=1, or len>6, or unknown pattern -> '?' (0x3F).
//   - A-Z map to uppercase ASCII. Example: A = len 2, dd=01. Q = len 4, dd=1101.
//   - 0-9: 0 = len 5, dd=11111; 5 = len 5, dd=00000.
//   - Punctuation: '.' = .-.-.-, ',' = --..--, '?' = ..--.., '/' = -..-., '=' = -...-.
//   - Bits of cap_dd at index >= len are ignored.
//   FSM IDLE (on cap_ceo=1):
//   - len>0 -> push decoded char at this edge.
//   - cap_word=1 and len>0 -> go to SPACE.
//   - cap_word=1 and len=0 -> push 0x20 directly at this edge; stay in IDLE.
//   - len=0 and cap_word=0 -> no push.
//   FSM SPACE: push 0x20 at the next enabled edge, then return to IDLE.
//   - A cap_ceo received while in SPACE is dropped and sets overflow.
//   Latency: a push at edge N with the FIFO empty makes char_valid=1 from cycle N+1.
//   - The space following a character lands one cycle later.
//   Pop: occurs when char_valid & char_ready at the edge; the head advances.
//   Push on full:
//   - If a pop happens on the same edge, both succeed and level is unchanged.
//   - Otherwise the push is dropped and overflow is set.
//   Push and ready on empty: push only; ready is ignored while valid=0.
//   Pointers wrap modulo FIFO_DEPTH. level tracks pushes minus pops exactly.
//   overflow stays set until rst or clear.
//   rst mid-operation: FIFO contents discarded and any pending space is lost.
//   ce=0: cap_ceo and char_ready are ignored. Outputs hold their values.
// TESTING
//   1 ceo, len=2, dd=01, word=0, ready=0 -> one cycle later valid=1, data=0x41, level=1.
//   2 ceo, len=1, dd=1, word=1 -> FIFO receives 'T' then ' ' on consecutive edges; level=2.
//   3 ceo, error=1, len=3 -> data=0x3F.
//   3b ceo, len=5, dd=10101 (unknown) -> data=0x3F.
//   4 ready=0, 9 char strobes (depth 8) -> level=8, overflow=1.
//   4b same full FIFO, next strobe with ready=1 -> push and pop succeed, level stays 8.
//   5 ceo, len=0, word=1 -> single 0x20 pushed.
//   5b strobe during SPACE -> dropped, overflow=1.
//   5c clear -> level=0, valid=0, overflow=0.
//   6 ce=0 while strobing and ready=1 -> no change.
//   6b assert rst with level=3 -> valid=0 and level=0 immediately (async).

Source files
------------

// File: rtl/morse_char_decode_fifo_if.sv
// Character stream from the Morse decoder to the text/UART sink.
//   char_data  : ASCII at FIFO head (show-ahead)
//   char_valid : FIFO holds at least one character
//   char_ready : sink accepts char_data this cycle
// master = decoder side, slave = sink side.
interface morse_char_decode_fifo_if;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/morse_char_decode_fifo.sv
// Decodes each captured Morse element pattern to ASCII and queues it, plus a
// trailing space on word gaps, in a FIFO drained over valid/ready.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ce                       clock enable, freezes all state when low
//   clear                    synchronous flush of FIFO, pending space, overflow
//   cap_ceo/len/dd/error/word  capture strobe and captured character
//   char_if (master)         char_data / char_valid / char_ready stream
//   level                    FIFO occupancy 0..FIFO_DEPTH
//   overflow                 sticky dropped-push flag
module morse_char_decode_fifo #(
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned MAX_LEN    = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    clear,
  input  logic                    cap_ceo,
  input  logic [LEN_W-1:0]        cap_len,
  input  logic [MAX_LEN-1:0]      cap_dd,
  input  logic                    cap_error,
  input  logic                    cap_word,
  morse_char_decode_fifo_if.master char_if,
  output logic [CNT_W-1:0]        level,
  output logic                    overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_QMARK = 8'h3F;

  typedef enum logic {IDLE, SPACE} state_t;

  state_t         state;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  logic [5:0]     pat;
  logic [8:0]     key;
  logic [7:0]     decoded;
  logic           push;
  logic [7:0]     push_data;
  logic           drop;
  logic           full;
  logic           pop;
  logic           push_ok;

  // Element pattern with bits at or above len forced to zero, keyed by length.
  always_comb begin
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat[i] = (LEN_W'(i) < cap_len) ? cap_dd[i] : 1'b0;
    end
    key = {3'(cap_len), pat};
  end

  // Pattern to ASCII; anything unrecognised becomes '?'.
  always_comb begin
    decoded = ASCII_QMARK;
    if (!cap_error && (cap_len <= LEN_W'(6))) begin
      case (key)
        {3'd2, 6'b000001}: decoded = 8'h41; // A
        {3'd4, 6'b001000}: decoded = 8'h42; // B
        {3'd4, 6'b001010}: decoded = 8'h43; // C
        {3'd3, 6'b000100}: decoded = 8'h44; // D
        {3'd1, 6'b000000}: decoded = 8'h45; // E
        {3'd4, 6'b000010}: decoded = 8'h46; // F
        {3'd3, 6'b000110}: decoded = 8'h47; // G
        {3'd4, 6'b000000}: decoded = 8'h48; // H
        {3'd2, 6'b000000}: decoded = 8'h49; // I
        {3'd4, 6'b000111}: decoded = 8'h4A; // J
        {3'd3, 6'b000101}: decoded = 8'h4B; // K
        {3'd4, 6'b000100}: decoded = 8'h4C; // L
        {3'd2, 6'b000011}: decoded = 8'h4D; // M
        {3'd2, 6'b000010}: decoded = 8'h4E; // N
        {3'd3, 6'b000111}: decoded = 8'h4F; // O
        {3'd4, 6'b000110}: decoded = 8'h50; // P
        {3'd4, 6'b001101}: decoded = 8'h51; // Q
        {3'd3, 6'b000010}: decoded = 8'h52; // R
        {3'd3, 6'b000000}: decoded = 8'h53; // S
        {3'd1, 6'b000001}: decoded = 8'h54; // T
        {3'd3, 6'b000001}: decoded = 8'h55; // U
        {3'd4, 6'b000001}: decoded = 8'h56; // V
        {3'd3, 6'b000011}: decoded = 8'h57; // W
        {3'd4, 6'b001001}: decoded = 8'h58; // X
        {3'd4, 6'b001011}: decoded = 8'h59; // Y
        {3'd4, 6'b001100}: decoded = 8'h5A; // Z
        {3'd5, 6'b011111}: decoded = 8'h30; // 0
        {3'd5, 6'b001111}: decoded = 8'h31; // 1
        {3'd5, 6'b000111}: decoded = 8'h32; // 2
        {3'd5, 6'b000011}: decoded = 8'h33; // 3
        {3'd5, 6'b000001}: decoded = 8'h34; // 4
        {3'd5, 6'b000000}: decoded = 8'h35; // 5
        {3'd5, 6'b010000}: decoded = 8'h36; // 6
        {3'd5, 6'b011000}: decoded = 8'h37; // 7
        {3'd5, 6'b011100}: decoded = 8'h38; // 8
        {3'd5, 6'b011110}: decoded = 8'h39; // 9
        {3'd6, 6'b010101}: decoded = 8'h2E; // .
        {3'd6, 6'b110011}: decoded = 8'h2C; // ,
        {3'd6, 6'b001100}: decoded = 8'h3F; // ?
        {3'd5, 6'b010010}: decoded = 8'h2F; // /
        {3'd5, 6'b010001}: decoded = 8'h3D; // =
        default:           decoded = ASCII_QMARK;
      endcase
    end
  end

  // Push request: a character, a direct space, or the deferred space after a word.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (cap_ceo) begin
          if (cap_len != '0) begin
            push      = 1'b1;
            push_data = decoded;
          end else if (cap_word) begin
            push      = 1'b1;
            push_data = ASCII_SPACE;
          end
        end
      end
      SPACE: begin
        push      = 1'b1;
        push_data = ASCII_SPACE;
        drop      = cap_ceo;
      end
      default: ;
    endcase
  end

  assign full    = (level == CNT_W'(FIFO_DEPTH));
  assign pop     = char_if.char_valid && char_if.char_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);

  assign char_if.char_data  = mem[rd_ptr];
  assign char_if.char_valid = (level != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (ce) begin
      if (clear) begin
        state    <= IDLE;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE:    state <= (cap_ceo && cap_word && (cap_len != '0)) ? SPACE : IDLE;
          SPACE:   state <= IDLE;
          default: state <= IDLE;
        endcase
        if (push_ok) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      level <= level + CNT_W'(1);
        else if (!push_ok && pop) level <= level - CNT_W'(1);
        if (drop || (push && !push_ok)) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_morse_char_decode_fifo.sv
// Directed bench: stimulus queues expected characters, a negedge monitor
// compares each accepted char against the queue head.
module tb_morse_char_decode_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       clear;
  logic       cap_ceo;
  logic [2:0] cap_len;
  logic [5:0] cap_dd;
  logic       cap_error;
  logic       cap_word;
  logic [3:0] level;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];

  typedef struct {
    int         len;
    logic [5:0] dd;
    bit         err;
    logic [7:0] exp;
  } vec_t;

  morse_char_decode_fifo_if cif();

  morse_char_decode_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .clear     (clear),
    .cap_ceo   (cap_ceo),
    .cap_len   (cap_len),
    .cap_dd    (cap_dd),
    .cap_error (cap_error),
    .cap_word  (cap_word),
    .char_if   (cif.master),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the coming posedge when valid & ready & ce.
  always @(negedge clk) begin
    if (!rst && ce && cif.char_valid && cif.char_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_char: got 0x%0h expected none", cif.char_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("char_data", int'(cif.char_data), int'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int len, input logic [5:0] dd, input bit err, input bit word);
    cap_ceo   = 1'b1;
    cap_len   = 3'(len);
    cap_dd    = dd;
    cap_error = err;
    cap_word  = word;
    cyc();
    cap_ceo   = 1'b0;
    cap_error = 1'b0;
    cap_word  = 1'b0;
  endtask

  task automatic drain(input string name);
    cif.char_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) cyc();
    chk({name, "_drained_level"}, int'(level), 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
    cif.char_ready = 1'b0;
  endtask

  vec_t dec_vecs [12] = '{
    '{3, 6'b000000, 1'b1, 8'h3F},
    '{5, 6'b010101, 1'b0, 8'h3F},
    '{7, 6'b000000, 1'b0, 8'h3F},
    '{5, 6'b011111, 1'b0, 8'h30},
    '{5, 6'b000000, 1'b0, 8'h35},
    '{4, 6'b001101, 1'b0, 8'h51},
    '{6, 6'b110011, 1'b0, 8'h2C},
    '{5, 6'b010001, 1'b0, 8'h3D},
    '{1, 6'b111110, 1'b0, 8'h45},
    '{6, 6'b010101, 1'b0, 8'h2E},
    '{5, 6'b010010, 1'b0, 8'h2F},
    '{6, 6'b001100, 1'b0, 8'h3F}
  };

  vec_t fill_vecs [9] = '{
    '{2, 6'b000001, 1'b0, 8'h41},
    '{4, 6'b001000, 1'b0, 8'h42},
    '{4, 6'b001010, 1'b0, 8'h43},
    '{3, 6'b000100, 1'b0, 8'h44},
    '{1, 6'b000000, 1'b0, 8'h45},
    '{4, 6'b000010, 1'b0, 8'h46},
    '{3, 6'b000110, 1'b0, 8'h47},
    '{4, 6'b000000, 1'b0, 8'h48},
    '{2, 6'b000000, 1'b0, 8'h49}
  };

  initial begin
    rst = 1'b1; ce = 1'b1; clear = 1'b0; cap_ceo = 1'b0; cap_len = '0;
    cap_dd = '0; cap_error = 1'b0; cap_word = 1'b0; cif.char_ready = 1'b0;
    #22 rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_valid", int'(cif.char_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_data", int'(cif.char_data), 0);

    // 1: 'A' lands one cycle after the strobe edge
    strobe(2, 6'b000001, 1'b0, 1'b0);
    sb.push_back(8'h41);
    chk("t1_valid", int'(cif.char_valid), 1);
    chk("t1_data", int'(cif.char_data), 8'h41);
    chk("t1_level", int'(level), 1);
    drain("t1");

    // 2: 'T' then space on the following edge
    strobe(1, 6'b000001, 1'b0, 1'b1);
    sb.push_back(8'h54);
    sb.push_back(8'h20);
    chk("t2_level_char", int'(level), 1);
    cyc();
    chk("t2_level_space", int'(level), 2);
    cyc();
    chk("t2_level_hold", int'(level), 2);
    drain("t2");

    // 3: decode table, errors and ignored high bits
    foreach (dec_vecs[i]) begin
      strobe(dec_vecs[i].len, dec_vecs[i].dd, dec_vecs[i].err, 1'b0);
      sb.push_back(dec_vecs[i].exp);
      if (i == 7) drain("t3a");
    end
    drain("t3b");

    // 4: nine strobes into depth 8 with ready low
    foreach (fill_vecs[i]) begin
      strobe(fill_vecs[i].len, fill_vecs[i].dd, 1'b0, 1'b0);
      if (i < 8) sb.push_back(fill_vecs[i].exp);
    end
    chk("t4_level", int'(level), 8);
    chk("t4_overflow", int'(overflow), 1);

    // 4b: push and pop on the same edge while full
    cif.char_ready = 1'b1;
    strobe(3, 6'b000101, 1'b0, 1'b0);
    cif.char_ready = 1'b0;
    sb.push_back(8'h4B);
    chk("t4b_level", int'(level), 8);
    drain("t4b");
    chk("t4b_overflow_sticky", int'(overflow), 1);

    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_overflow", int'(overflow), 0);

    // 5: word gap with empty char pushes a single space
    strobe(0, 6'b000000, 1'b0, 1'b1);
    sb.push_back(8'h20);
    chk("t5_level", int'(level), 1);
    chk("t5_data", int'(cif.char_data), 8'h20);
    cyc();
    chk("t5_level_hold", int'(level), 1);

    // 5b: strobe while the deferred space is pending is dropped
    strobe(1, 6'b000000, 1'b0, 1'b1);
    strobe(1, 6'b000001, 1'b0, 1'b0);
    chk("t5b_level", int'(level), 3);
    chk("t5b_overflow", int'(overflow), 1);
    cyc();
    chk("t5b_level_hold", int'(level), 3);

    // 5c: clear flushes everything
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    sb.delete();
    chk("t5c_level", int'(level), 0);
    chk("t5c_valid", int'(cif.char_valid), 0);
    chk("t5c_overflow", int'(overflow), 0);

    // 6: ce low freezes state
    for (int i = 0; i < 3; i++) begin
      strobe(fill_vecs[i].len, fill_vecs[i].dd, 1'b0, 1'b0);
      sb.push_back(fill_vecs[i].exp);
    end
    ce = 1'b0;
    cif.char_ready = 1'b1;
    strobe(1, 6'b000001, 1'b0, 1'b1);
    strobe(0, 6'b000000, 1'b0, 1'b1);
    cyc();
    chk("t6_level", int'(level), 3);
    chk("t6_data", int'(cif.char_data), 8'h41);
    chk("t6_overflow", int'(overflow), 0);
    cif.char_ready = 1'b0;
    ce = 1'b1;
    cyc();
    chk("t6_level_after", int'(level), 3);

    // 6b: asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6b_valid", int'(cif.char_valid), 0);
    chk("t6b_level", int'(level), 0);
    sb.delete();
    cyc();
    rst = 1'b0;
    cyc();

    // Operation resumes after reset
    strobe(1, 6'b000001, 1'b0, 1'b0);
    sb.push_back(8'h54);
    chk("post_rst_level", int'(level), 1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
